// File: rtl/link_tx_serializer_pkg.sv
// link_tx_serializer_pkg: shared widths, packet/flit types and header helper for the link transmit stage
package link_tx_serializer_pkg;
  localparam int CHANNEL_WIDTH = 32;
  localparam int FLITS_PER_PACKET = 5;
  localparam int PACKET_WIDTH = CHANNEL_WIDTH * FLITS_PER_PACKET;
  localparam int BUFFER_DEPTH = 4;
  localparam int CREDIT_WIDTH = 3;
  localparam int FLIT_CNT_WIDTH = 3;
  typedef logic [PACKET_WIDTH-1:0] packet_t;
  typedef logic [CHANNEL_WIDTH-1:0] flit_t;
  typedef logic [CREDIT_WIDTH-1:0] credit_t;
  typedef logic [FLIT_CNT_WIDTH-1:0] flit_cnt_t;
  localparam credit_t CREDIT_MAX = credit_t'(BUFFER_DEPTH);
  localparam flit_cnt_t LAST_FLIT = flit_cnt_t'(FLITS_PER_PACKET);
  function automatic flit_t header_of(packet_t p);
    return p[PACKET_WIDTH-1 -: CHANNEL_WIDTH];
  endfunction
endpackage

// File: rtl/link_tx_serializer_if.sv
// link_tx_serializer_if: whole-packet valid/ready handshake into the transmit stage
//   packet_din        160-bit packet, header flit in the top 32 bits
//   packet_valid_din  packet_din valid
//   packet_ready_dout transmit stage accepts a packet this cycle
interface link_tx_serializer_if;
  import link_tx_serializer_pkg::*;
  packet_t packet_din;
  logic packet_valid_din;
  logic packet_ready_dout;
  modport master (output packet_din, output packet_valid_din, input packet_ready_dout);
  modport slave (input packet_din, input packet_valid_din, output packet_ready_dout);
endinterface

// File: rtl/link_tx_serializer_credit_counter.sv
// link_credit_counter: edge-detected credit return with saturating up/down packet-slot counter
//   clk, reset     clock and async active-high reset
//   credit_i       receiver credit line, level; each rising edge frees one slot
//   consume_i      one slot used this cycle
//   credits_o      current credit count
//   available_o    at least one credit held
//   overflow_o     credit returned while already at full depth (one-cycle pulse)
module link_credit_counter
  import link_tx_serializer_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    credit_i,
  input  logic    consume_i,
  output credit_t credits_o,
  output logic    available_o,
  output logic    overflow_o
);
  logic credit_q;
  credit_t count_q, count_d;
  logic inc;
  assign inc = credit_i && !credit_q;
  // a return and a consume on the same edge cancel, so only lone events move the count
  always_comb begin
    overflow_o = inc && !consume_i && count_q == CREDIT_MAX;
    count_d = (inc && !consume_i && !overflow_o) ? count_q + 1'b1 :
              (consume_i && !inc) ? count_q - 1'b1 : count_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credit_q <= 1'b0;
      count_q <= CREDIT_MAX;
    end else begin
      credit_q <= credit_i;
      count_q <= count_d;
    end
  end
  assign credits_o = count_q;
  assign available_o = count_q != '0;
endmodule

// File: rtl/link_tx_serializer.sv
// link_tx_serializer: credit-gated 160-bit packet to 5x32-bit flit serializer with forced idle gap
//   clk, reset        clock and async active-high reset
//   pkt               packet valid/ready handshake (slave side)
//   channel_out       registered link channel, 0 = idle
//   credit_in         receiver credit return, level; rising edge = one slot freed
//   credit_count_dout current credits
//   busy_dout         packet on the link (SEND or GAP)
//   error_dout        sticky: zero-header packet dropped or credit overflow
module link_tx_serializer
  import link_tx_serializer_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  link_tx_serializer_if.slave pkt,
  output flit_t   channel_out,
  input  logic    credit_in,
  output credit_t credit_count_dout,
  output logic    busy_dout,
  output logic    error_dout
);
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  state_t state_q, state_d;
  packet_t shift_q, shift_d;
  flit_cnt_t cnt_q, cnt_d;
  flit_t chan_q, chan_d;
  logic err_q, err_d;
  logic avail, overflow, xfer, hdr_zero, consume;
  link_credit_counter u_credit (
    .clk(clk),
    .reset(reset),
    .credit_i(credit_in),
    .consume_i(consume),
    .credits_o(credit_count_dout),
    .available_o(avail),
    .overflow_o(overflow)
  );
  assign pkt.packet_ready_dout = state_q == IDLE && avail && !reset;
  assign xfer = pkt.packet_valid_din && pkt.packet_ready_dout;
  assign hdr_zero = header_of(pkt.packet_din) == '0;
  // a zero header would look like idle to the receiver, so such packets are swallowed without a credit
  assign consume = xfer && !hdr_zero;
  // channel defaults to idle; only an accept or an in-flight SEND drives a flit
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d = cnt_q;
    chan_d = '0;
    err_d = err_q || overflow || (xfer && hdr_zero);
    case (state_q)
      IDLE: if (consume) begin
        state_d = SEND;
        chan_d = header_of(pkt.packet_din);
        shift_d = pkt.packet_din << CHANNEL_WIDTH;
        cnt_d = flit_cnt_t'(1);
      end
      SEND: if (cnt_q == LAST_FLIT) begin
        state_d = GAP;
        cnt_d = '0;
      end else begin
        chan_d = header_of(shift_q);
        shift_d = shift_q << CHANNEL_WIDTH;
        cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q <= '0;
      chan_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q <= cnt_d;
      chan_q <= chan_d;
      err_q <= err_d;
    end
  end
  assign channel_out = chan_q;
  assign busy_dout = state_q != IDLE;
  assign error_dout = err_q;
endmodule

// File: doc/link_tx_serializer.md
Name: link_tx_serializer

Overview:
Synthesizable transmit stage that sits directly upstream of the network receive endpoint (a router input port or the verification sink).
- Accepts a whole 160-bit packet through a valid/ready handshake.
- Serializes it MSB-flit-first as 5 × 32-bit flits onto the link channel.
- Gates transmission on a credit counter replenished by the receiver's credit line.
- Guarantees the link idle encoding (all-zero channel) between packets, so receivers that detect packet start by a channel change always see a fresh header.

Parameters:
CHANNEL_WIDTH, 32, flit width in bits
FLITS_PER_PACKET, 5, flits per packet (packet width = CHANNEL_WIDTH*FLITS_PER_PACKET = 160)
BUFFER_DEPTH, 4, packet slots at receiver; initial and maximum credit count
CREDIT_WIDTH, 3, width of the credit counter; must hold BUFFER_DEPTH

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
packet_din  input  160  packet; [159:128] header flit, [127:0] four data flits
packet_valid_din  input  1  packet_din valid
packet_ready_dout  output  1  block accepts packet this cycle
channel_out  output  32  link channel, registered; 0 = idle
credit_in  input  1  credit return from receiver, level signal; each rising edge = one packet slot freed
credit_count_dout  output  CREDIT_WIDTH  current credits
busy_dout  output  1  high while a packet is on the link (SEND or GAP)
error_dout  output  1  sticky: zero-header packet dropped or credit overflow

Behaviour:
- Reset (async, immediate) values:
  - channel_out = 0, packet_ready_dout = 0, busy_dout = 0, error_dout = 0
  - credit_count_dout = BUFFER_DEPTH
  - state = IDLE, flit counter = 0, credit_in edge register = 0
- Handshake: packet_ready_dout = (state == IDLE) && (credits > 0) && !reset. Transfer occurs when valid && ready at a rising edge.
- FSM states: IDLE, SEND, GAP.
  - IDLE: on transfer with header != 0, load a 160-bit shift register, decrement credits, drive channel_out = header flit on the same edge, flit counter = 1, go to SEND.
  - IDLE: on transfer with header == 0, consume the packet without sending, leave credits unchanged, set error_dout, stay IDLE.
  - SEND: each edge shifts left 32 and drives the next flit; after flit 5 is driven for one cycle, the next edge drives channel_out = 0 and goes to GAP.
  - GAP: exactly one idle cycle with channel_out = 0, then IDLE. GAP is mandatory even when data is pending.
- Timing:
  - Latency from accept edge to header on channel_out: 0 cycles after that edge (registered output).
  - Each flit holds for exactly one cycle.
  - Minimum packet spacing is 7 cycles: 5 flits, 1 forced zero, 1 IDLE accept.
  - Data flits equal to 0 are transmitted as-is; only the header must be nonzero.
- Credits:
  - credit_in is registered once (credit_q); an increment event is credit_in && !credit_q.
  - Increment and decrement on the same edge: net unchanged.
  - Increment at BUFFER_DEPTH: saturate at BUFFER_DEPTH and set error_dout.
  - Decrement never occurs at 0, because ready is low.
- credit_in is sampled in all states, including during SEND.
- Reset mid-packet: channel_out goes to 0 immediately; the partial packet is abandoned (the receiver is reset with the link); credits return to BUFFER_DEPTH.
- packet_din is only sampled at the transfer edge; its changes during SEND have no effect.
- error_dout clears only on reset.

Decomposition:
- Shared header (system.vh / packet_type.vh): CHANNEL_WIDTH, packet width, flit count, packet type macro, port identifiers.
- FSM state encodings stay local parameters.
- One sub-module: link_credit_counter. It holds the edge detect, saturating up/down counter, overflow flag, and exposes credits_available.

Test Plan:
1. Reset, send packet 0x00000_ABC followed by data 11111111/22222222/33333333/44444444 (header 0x00000ABC) → channel shows 00000ABC, 11111111, 22222222, 33333333, 44444444 on consecutive cycles, then 0; credit_count goes 4→3.
2. Hold valid with 4 packets and no credit returns → 4 packets sent, each separated by ≥1 zero cycle; ready stays low after the 4th; credit_count = 0; the fifth packet is sent only after one credit_in rising edge.
3. Credit_in rising edge on the same edge as an accept → credit_count unchanged (e.g. 2→2).
4. Header = 0 with valid → no flits on channel, error_dout = 1, credit_count unchanged, next valid packet sent normally.
5. Credit_in pulses with credit_count = 4 → stays 4, error_dout = 1.
6. Assert reset during flit 3 → channel_out = 0 within the same cycle (async), credit_count = 4, busy = 0; a fresh packet after reset is sent from its header.
